// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// One operation in flight: accept, execute for one cycle, hold the response until consumed.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic grant;
  logic any_valid;
  logic idle_open;

  // With both requesters pending, the one not served last wins.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    grant      = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    idle_open  = (state_q == IDLE) && !rst;
    req0_ready = idle_open && req0_valid && !grant;
    req1_ready = idle_open && req1_valid && grant;
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = EXEC;
          owner_d = grant;
          a_d     = grant ? req1_a  : req0_a;
          b_d     = grant ? req1_b  : req0_b;
          op_d    = grant ? req1_op : req0_op;
        end
      end
      EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to 1 so that requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;

  assign rsp0_valid  = (state_q == RESP) && !owner_q;
  assign rsp1_valid  = (state_q == RESP) && owner_q;
  assign rsp0_result = owner_q ? '0 : result_q;
  assign rsp1_result = owner_q ? result_q : '0;
  assign rsp0_zero   = !owner_q && zero_q;
  assign rsp1_zero   = owner_q && zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stub ALU, a transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_alu_arbiter;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_op, req1_op;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [3:0]    alu_control;
  logic          alu_zero;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0]  rsp0_result, rsp1_result;
  logic          rsp0_zero, rsp1_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero)
  );

  // Stub ALU: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLT, 8 SRA, 9 SLTU, else 0.
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a ^ b;
      4'd4: return a << b[4:0];
      4'd5: return a >> b[4:0];
      4'd6: return a - b;
      4'd7: return (sa < sb) ? 32'd1 : 32'd0;
      4'd8: return sa >>> b[4:0];
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_control);
  assign alu_zero   = (alu_result == '0);

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Transaction-level model: m_age counts cycles since acceptance (1 = executing, 2 = responding).
  bit           model_ok = 1'b0;
  bit           m_busy, m_owner, m_last;
  int           m_age;
  logic [W-1:0] m_a, m_b, m_res;
  logic [3:0]   m_op;
  logic         m_zero;

  always @(posedge clk) begin
    int g;
    g = pick(req0_valid, req1_valid, m_last);
    if (rst) begin
      model_ok = 1'b1;
      m_busy = 1'b0; m_age = 0; m_last = 1'b1; m_owner = 1'b0;
      m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_zero = 1'b0;
    end else if (!m_busy) begin
      if (g >= 0) begin
        m_busy  = 1'b1;
        m_age   = 1;
        m_owner = (g == 1);
        m_a     = (g == 1) ? req1_a  : req0_a;
        m_b     = (g == 1) ? req1_b  : req0_b;
        m_op    = (g == 1) ? req1_op : req0_op;
      end
    end else if (m_age == 1) begin
      m_age  = 2;
      m_res  = alu_fn(m_a, m_b, m_op);
      m_zero = (m_res == '0);
    end else if (m_owner ? rsp1_ready : rsp0_ready) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end
  end

  always @(negedge clk) begin
    int g;
    bit resp;
    g    = pick(req0_valid, req1_valid, m_last);
    resp = m_busy && (m_age == 2);
    if (model_ok) begin
      check("req0_ready", req0_ready, !rst && !m_busy && g == 0);
      check("req1_ready", req1_ready, !rst && !m_busy && g == 1);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_control", alu_control, m_op);
      check("rsp0_valid", rsp0_valid, resp && !m_owner);
      check("rsp1_valid", rsp1_valid, resp && m_owner);
      if (resp) begin
        check("rsp0_result", rsp0_result, m_owner ? '0 : m_res);
        check("rsp1_result", rsp1_result, m_owner ? m_res : '0);
        check("rsp0_zero", rsp0_zero, !m_owner && m_zero);
        check("rsp1_zero", rsp1_zero, m_owner && m_zero);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic get_rsp(output int who, output logic [W-1:0] r, output logic z);
    who = -1;
    r   = '0;
    z   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp0_valid) begin who = 0; r = rsp0_result; z = rsp0_zero; break; end
      if (rsp1_valid) begin who = 1; r = rsp1_result; z = rsp1_zero; break; end
    end
    if (who < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got no response within 20 cycles, required one at %0t", $time);
    end
  endtask

  initial begin
    int           who;
    int           cyc;
    logic [W-1:0] r;
    logic         z;

    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset state, with a request pending that must not be offered ready
    step();
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_alu_a", alu_a, 0);
    step();
    rst = 1'b0;

    // Single ADD, latency 2
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd5; req0_op = 4'b0010;
    @(negedge clk);
    check("s1_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp0_valid) begin cyc = k; break; end
    end
    check("s1_latency", cyc, 2);
    check("s1_result", rsp0_result, 32'd12);
    check("s1_zero", rsp0_zero, 0);
    $display("txn s1: req0 ADD 7+5 -> 0x%08h zero=%0d after %0d cycles", rsp0_result, rsp0_zero, cyc);
    step();
    @(negedge clk);
    check("s1_idle", rsp0_valid, 0);

    // Contention, alternation while both held valid
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd9;    req0_b = 32'd9;    req0_op = 4'b0110;
    req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_op = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      get_rsp(who, r, z);
      check("s2_owner", who, i % 2);
      check("s2_result", r, (i % 2) ? 32'hFF : 32'h0);
      check("s2_zero", z, (i % 2) ? 0 : 1);
      $display("txn s2.%0d: owner %0d -> 0x%08h zero=%0d", i, who, r, z);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure on requester 1 while requester 0 waits
    do_reset();
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'b0010;
    get_rsp(who, r, z);
    check("s3_owner", who, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) begin
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0010;
      end
      @(negedge clk);
      check("s3_hold_valid", rsp1_valid, 1);
      check("s3_hold_result", rsp1_result, 32'd7);
      check("s3_req0_ready", req0_ready, 0);
    end
    step();
    rsp1_ready = 1'b1;
    step();
    @(negedge clk);
    check("s3_release_idle", req0_ready, 1);
    check("s3_release_rsp1", rsp1_valid, 0);
    get_rsp(who, r, z);
    check("s3_req0_result", r, 32'd2);
    $display("txn s3: req1 held 5 cycles -> 7, then req0 -> 0x%08h", r);
    step();
    req0_valid = 1'b0;

    // Operand stability after acceptance
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_op = 4'b0010;
    @(negedge clk);
    check("s4_ready", req0_ready, 1);
    step();
    req0_a = 32'd555; req0_b = 32'd9; req0_op = 4'b0110;
    @(negedge clk);
    check("s4_alu_a", alu_a, 32'd100);
    get_rsp(who, r, z);
    check("s4_result", r, 32'd101);
    $display("txn s4: req0 ADD 100+1 with inputs changed -> 0x%08h", r);
    step();
    req0_valid = 1'b0;

    // Reset while executing
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'b0010;
    step();
    req0_valid = 1'b0;
    get_rsp(who, r, z);
    step();
    req0_valid = 1'b1; req0_a = 32'd20; req0_b = 32'd22;
    step();
    rst = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("s5_rst_ready", req0_ready, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("s5_no_rsp0", rsp0_valid, 0);
      check("s5_no_rsp1", rsp1_valid, 0);
      step();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("s5_prio_req0", req0_ready, 1);
    check("s5_prio_req1", req1_ready, 0);
    $display("txn s5: reset in EXEC discarded, priority back to requester 0");
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    get_rsp(who, r, z);
    step();

    // Shift / compare / undefined opcode pass-through
    do_reset();
    req0_valid = 1'b1; req0_a = 32'h8000_0000; req0_b = 32'd4; req0_op = 4'd8;
    step();
    req0_valid = 1'b0;
    get_rsp(who, r, z);
    check("s6_sra", r, 32'hF800_0000);
    $display("txn s6: SRA 0x80000000>>>4 -> 0x%08h", r);
    step();
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'hFFFF_FFFF; req1_op = 4'd9;
    step();
    req1_valid = 1'b0;
    get_rsp(who, r, z);
    check("s6_sltu_owner", who, 1);
    check("s6_sltu", r, 32'd1);
    $display("txn s6: SLTU 1<0xFFFFFFFF -> 0x%08h", r);
    step();
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd6; req1_op = 4'hF;
    step();
    req1_valid = 1'b0;
    get_rsp(who, r, z);
    check("s6_undef_result", r, 32'd0);
    check("s6_undef_zero", z, 1);
    step();

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      req0_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      req0_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      req1_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      req1_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      req0_op    = 4'($urandom_range(0, 15));
      req1_op    = 4'($urandom_range(0, 15));
      rsp0_ready = ($urandom_range(0, 99) < 70);
      rsp1_ready = ($urandom_range(0, 99) < 70);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
